mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have I_clk input 1: system clock; all state changes on its rising edge.
REQ-002 SHALL have I_reset input 1: reset, synchronous, active-high.
REQ-003 SHALL have I_enable input 1: request strobe, sampled with the request fields below.
REQ-004 SHALL have I_memory_mode input 2: MEM_NOP / MEM_READ / MEM_WRITE from the shared mem_acc constants.
REQ-005 SHALL have I_memory_size input 2: access width in bytes (1 or 2).
REQ-006 SHALL have I_addr input 16: byte address of the access.
REQ-007 SHALL have I_wdata input 16: write data, low byte first.
REQ-008 SHALL have O_rdata output 16: read result.
REQ-009 SHALL have O_busy output 1: request in progress.
REQ-010 SHALL have O_done output 1: one-cycle completion pulse.
REQ-011 SHALL have O_error output 1: one-cycle pulse with O_done on an illegal request.
REQ-012 SHALL have O_bus_addr output 16: byte-bus address.
REQ-013 SHALL have O_bus_wdata output 8: byte-bus write data.
REQ-014 SHALL have O_bus_re output 1: byte-bus read strobe.
REQ-015 SHALL have O_bus_we output 1: byte-bus write strobe.
REQ-016 SHALL have I_bus_rdata input 8: byte-bus read data, valid when I_bus_ready=1.
REQ-017 SHALL have I_bus_ready input 1: byte-bus completes the current byte.

Function
REQ-018 SHALL implement states IDLE, BYTE0, BYTE1, FINISH.
REQ-019 SHALL accept a request on a rising edge where I_enable=1 and O_busy=0, latching mode, size, addr and wdata.
REQ-020 SHALL ignore I_enable while O_busy=1.
REQ-021 SHALL treat as illegal: mode not in {NOP, READ, WRITE}, or READ/WRITE with size not in {1, 2}.
REQ-022 An accepted NOP or illegal request SHALL go IDLE->FINISH with no bus strobe; O_error SHALL be 1 for illegal requests.
REQ-023 An accepted READ or WRITE SHALL go IDLE->BYTE0, driving O_bus_addr=addr and the strobe for the mode; WRITE drives O_bus_wdata=wdata[7:0].
REQ-024 In BYTE0 or BYTE1, bus outputs SHALL hold stable until an edge with I_bus_ready=1; wait states are unbounded.
REQ-025 On BYTE0 ready: size 1 -> FINISH; size 2 -> BYTE1 with O_bus_addr=addr+1 (16-bit wrap, 0xFFFF+1=0x0000) and O_bus_wdata=wdata[15:8].
REQ-026 On BYTE1 ready: -> FINISH.
REQ-027 Byte order SHALL be little-endian: the low byte is at addr and the high byte at addr+1.
REQ-028 A READ SHALL set O_rdata[7:0] from the BYTE0 byte; O_rdata[15:8] SHALL be the BYTE1 byte for size 2 and 0x00 for size 1.
REQ-029 O_rdata SHALL be unchanged by WRITE, NOP and illegal requests, and SHALL be updated no later than the cycle O_done is asserted.
REQ-030 O_busy SHALL be 1 in BYTE0 and BYTE1 and 0 in IDLE and FINISH.
REQ-031 O_done SHALL be 1 only in FINISH, which SHALL last exactly one cycle.
REQ-032 A request accepted in FINISH SHALL be handled exactly as if accepted in IDLE (back-to-back operation).
REQ-033 O_bus_re and O_bus_we SHALL never both be 1, and SHALL both be 0 outside BYTE0 and BYTE1.
REQ-034 Latency with I_bus_ready tied 1: O_done SHALL be asserted 2 cycles after acceptance for size 1, 3 cycles for size 2, and 1 cycle for NOP or illegal requests.

Reset
REQ-035 While I_reset=1, the state SHALL be IDLE and O_rdata, O_busy, O_done, O_error, O_bus_addr, O_bus_wdata, O_bus_re and O_bus_we SHALL all be 0.
REQ-036 Reset mid-access SHALL abort the access: strobes drop on the next edge and no O_done is produced.
REQ-037 Reset SHALL take priority over I_enable and I_bus_ready.

Structure
REQ-038 MEM_NOP=0, MEM_READ=1, MEM_WRITE=2 SHALL come from the shared mem_acc constants file used by the ALU; state encodings SHALL stay local.
REQ-039 SHALL be a single module with no sub-module.

Verification
REQ-040 Ready tied 1, READ size 2 at 0x1000, bus bytes 0x34 then 0x12 -> O_rdata=0x1234, O_done 3 cycles after accept.
REQ-041 WRITE size 2 at 0xFFFF, wdata=0xBEEF, ready tied 1 -> byte writes 0xEF@0xFFFF then 0xBE@0x0000, O_done once.
REQ-042 READ size 1 at 0x0020, byte 0xA5, ready low for 3 cycles -> address and strobe held stable, O_rdata=0x00A5, O_done 5 cycles after accept.
REQ-043 READ with size 3, and mode 3 -> no bus strobe, O_done=O_error=1 one cycle after accept, O_rdata unchanged.
REQ-044 Reset asserted in BYTE1 of a size-2 WRITE -> strobes 0 next cycle, no O_done, all outputs 0; a new request is accepted after reset.
REQ-045 Second request presented during FINISH -> accepted without an idle cycle; I_enable pulses while busy are ignored.

Source files
------------

// File: rtl/mem_acc_pkg.sv
// Shared memory-access constants (also used by the ALU).
// Contents:
//   MEM_NOP / MEM_READ / MEM_WRITE : 2-bit access mode encodings
//   MEM_SIZE_BYTE / MEM_SIZE_HALF  : legal access widths in bytes
package mem_acc_pkg;

    localparam logic [1:0] MEM_NOP   = 2'd0;
    localparam logic [1:0] MEM_READ  = 2'd1;
    localparam logic [1:0] MEM_WRITE = 2'd2;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd1;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd2;

endpackage

// File: rtl/mem_ctrl.sv
// Memory access controller: splits a 1- or 2-byte request into little-endian
// accesses on a byte-wide bus with ready handshake.
// Ports:
//   I_clk, I_reset           : clock, synchronous active-high reset
//   I_enable                 : request strobe (accepted when not busy)
//   I_memory_mode/size/addr  : request fields (mode from mem_acc_pkg, size 1 or 2)
//   I_wdata                  : write data, low byte first
//   O_rdata                  : read result
//   O_busy / O_done / O_error: status; done and error pulse for one cycle
//   O_bus_addr/wdata/re/we   : byte-bus request
//   I_bus_rdata, I_bus_ready : byte-bus response
module mem_ctrl
    import mem_acc_pkg::*;
(
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_enable,
    input  logic [1:0]  I_memory_mode,
    input  logic [1:0]  I_memory_size,
    input  logic [15:0] I_addr,
    input  logic [15:0] I_wdata,
    output logic [15:0] O_rdata,
    output logic        O_busy,
    output logic        O_done,
    output logic        O_error,
    output logic [15:0] O_bus_addr,
    output logic [7:0]  O_bus_wdata,
    output logic        O_bus_re,
    output logic        O_bus_we,
    input  logic [7:0]  I_bus_rdata,
    input  logic        I_bus_ready
);

    typedef enum logic [1:0] {StIdle, StByte0, StByte1, StFinish} state_e;

    state_e      r_state, w_state_next;
    logic        r_is_write;
    logic        r_size2;
    logic        r_error;
    logic [15:0] r_rdata;
    logic [15:0] r_bus_addr;
    logic [7:0]  r_bus_wdata;
    logic [7:0]  r_wdata_hi;

    logic        w_can_accept;
    logic        w_req_legal;
    logic        w_req_bus;
    logic        w_busy;

    // FINISH is not busy, so a new request can be taken there back-to-back.
    assign w_can_accept = (r_state == StIdle) || (r_state == StFinish);
    assign w_busy       = (r_state == StByte0) || (r_state == StByte1);

    always_comb begin
        w_req_legal = 1'b0;
        case (I_memory_mode)
            MEM_NOP:             w_req_legal = 1'b1;
            MEM_READ, MEM_WRITE: w_req_legal = (I_memory_size == MEM_SIZE_BYTE) ||
                                               (I_memory_size == MEM_SIZE_HALF);
            default:             w_req_legal = 1'b0;
        endcase
    end

    assign w_req_bus = w_req_legal && (I_memory_mode != MEM_NOP);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle, StFinish: begin
                if (I_enable) begin
                    w_state_next = w_req_bus ? StByte0 : StFinish;
                end else begin
                    w_state_next = StIdle;
                end
            end
            StByte0: begin
                if (I_bus_ready) begin
                    w_state_next = r_size2 ? StByte1 : StFinish;
                end
            end
            StByte1: begin
                if (I_bus_ready) begin
                    w_state_next = StFinish;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_is_write  <= 1'b0;
            r_size2     <= 1'b0;
            r_error     <= 1'b0;
            r_rdata     <= 16'h0000;
            r_bus_addr  <= 16'h0000;
            r_bus_wdata <= 8'h00;
            r_wdata_hi  <= 8'h00;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                StIdle, StFinish: begin
                    if (I_enable) begin
                        if (w_req_bus) begin
                            r_is_write  <= (I_memory_mode == MEM_WRITE);
                            r_size2     <= (I_memory_size == MEM_SIZE_HALF);
                            r_bus_addr  <= I_addr;
                            r_bus_wdata <= I_wdata[7:0];
                            r_wdata_hi  <= I_wdata[15:8];
                        end else begin
                            r_error <= !w_req_legal;
                        end
                    end
                end
                StByte0: begin
                    if (I_bus_ready) begin
                        // High byte cleared here; a size-2 read fills it in BYTE1.
                        if (!r_is_write) begin
                            r_rdata <= {8'h00, I_bus_rdata};
                        end
                        if (r_size2) begin
                            r_bus_addr  <= r_bus_addr + 16'd1;
                            r_bus_wdata <= r_wdata_hi;
                        end
                    end
                end
                StByte1: begin
                    if (I_bus_ready && !r_is_write) begin
                        r_rdata[15:8] <= I_bus_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign O_rdata     = r_rdata;
    assign O_busy      = w_busy;
    assign O_done      = (r_state == StFinish);
    assign O_error     = r_error;
    assign O_bus_addr  = r_bus_addr;
    assign O_bus_wdata = r_bus_wdata;
    assign O_bus_re    = w_busy && !r_is_write;
    assign O_bus_we    = w_busy && r_is_write;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed cases plus randomized requests
// against a transaction-level model and a byte-addressable bus slave.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        busy, done, err;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_re, bus_we;
    logic [7:0]  bus_rdata;
    logic        bus_ready;

    logic [7:0]  mem [0:65535];
    logic [15:0] model_rdata;
    int          n_cmp;
    int          n_bad;

    mem_ctrl u_dut (
        .I_clk         (clk),
        .I_reset       (rst),
        .I_enable      (en),
        .I_memory_mode (mode),
        .I_memory_size (size),
        .I_addr        (addr),
        .I_wdata       (wdata),
        .O_rdata       (rdata),
        .O_busy        (busy),
        .O_done        (done),
        .O_error       (err),
        .O_bus_addr    (bus_addr),
        .O_bus_wdata   (bus_wdata),
        .O_bus_re      (bus_re),
        .O_bus_we      (bus_we),
        .I_bus_rdata   (bus_rdata),
        .I_bus_ready   (bus_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {rdata, busy, done, err, bus_addr, bus_wdata, bus_re, bus_we}, 0);
    endtask

    // Issue one request at the current negedge and follow it to O_done.
    // first_waits: forced wait states on byte 0; rnd: random ready afterwards.
    task automatic do_req(input logic [1:0] m, input logic [1:0] s, input logic [15:0] a,
                          input logic [15:0] wd, input int first_waits, input bit rnd);
        bit          bad;
        int          nbytes, b, wb, n, exp_lat;
        bit          got_done, rdy;
        logic [15:0] exp_rd;
        logic [15:0] a1;
        logic [15:0] ea;
        bad    = (m == 2'd3) || ((m == 2'd1 || m == 2'd2) && !(s == 2'd1 || s == 2'd2));
        nbytes = (bad || m == 2'd0) ? 0 : int'(s);
        a1     = a + 16'd1;
        exp_rd = model_rdata;
        if (!bad && m == 2'd1) exp_rd = {(s == 2'd2) ? mem[a1] : 8'h00, mem[a]};
        en = 1'b1; mode = m; size = s; addr = a; wdata = wd; bus_ready = 1'b0;
        @(negedge clk);
        n = 1; b = 0; wb = 0; exp_lat = 1; got_done = 0;
        while (n < 300) begin
            en = 1'b0;
            bus_ready = 1'b0;
            chk("re_we_excl", {31'd0, bus_re & bus_we}, 0);
            if (!busy) chk("strobe_not_busy", {30'd0, bus_re, bus_we}, 0);
            if (done) begin
                got_done = 1;
                break;
            end
            if (busy) begin
                ea = a + 16'(b);
                chk("bus_addr", {16'd0, bus_addr}, {16'd0, ea});
                chk("bus_re", {31'd0, bus_re}, {31'd0, m == 2'd1});
                chk("bus_we", {31'd0, bus_we}, {31'd0, m == 2'd2});
                if (m == 2'd2) chk("bus_wdata", {24'd0, bus_wdata}, {24'd0, b != 0 ? wd[15:8] : wd[7:0]});
                if (b == 0 && wb < first_waits) rdy = 0;
                else rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                bus_ready = rdy;
                bus_rdata = rdy ? mem[bus_addr] : 8'($urandom);
                if (rdy) begin
                    if (bus_we) mem[bus_addr] = bus_wdata;
                    b++;
                    wb = 0;
                end else begin
                    wb++;
                end
                exp_lat++;
                // Junk on the request port while busy must be ignored.
                en = 1'($urandom); mode = 2'($urandom); size = 2'($urandom);
                addr = 16'($urandom); wdata = 16'($urandom);
            end
            @(negedge clk);
            n++;
        end
        en = 1'b0;
        bus_ready = 1'b0;
        chk("done_seen", {31'd0, got_done}, 1);
        chk("latency", n, exp_lat);
        chk("bytes", b, nbytes);
        chk("error", {31'd0, err}, {31'd0, bad});
        chk("rdata", {16'd0, rdata}, {16'd0, exp_rd});
        chk("busy_at_done", {31'd0, busy}, 0);
        model_rdata = exp_rd;
    endtask

    task automatic idle_gap();
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 0);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_error", {31'd0, err}, 0);
    endtask

    initial begin
        logic [1:0]  m, s;
        logic [15:0] a;
        n_cmp = 0; n_bad = 0; model_rdata = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst = 1'b1; en = 1'b1; mode = 2'd1; size = 2'd2; addr = 16'h1234; wdata = 16'hFFFF;
        bus_rdata = 8'h00; bus_ready = 1'b1;
        @(negedge clk);
        chk_all_zero("reset1");
        @(negedge clk);
        chk_all_zero("reset2");
        rst = 1'b0; en = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        chk_all_zero("after_reset");

        // Size-2 read, ready tied high.
        mem[16'h1000] = 8'h34; mem[16'h1001] = 8'h12;
        do_req(2'd1, 2'd2, 16'h1000, 16'h0000, 0, 0);
        chk("read16_value", {16'd0, rdata}, 32'h1234);
        idle_gap();

        // Size-2 write wrapping at the top of the address space.
        do_req(2'd2, 2'd2, 16'hFFFF, 16'hBEEF, 0, 0);
        chk("wrap_low_byte", {24'd0, mem[16'hFFFF]}, 32'hEF);
        chk("wrap_high_byte", {24'd0, mem[16'h0000]}, 32'hBE);
        idle_gap();

        // Size-1 read with three wait states.
        mem[16'h0020] = 8'hA5;
        do_req(2'd1, 2'd1, 16'h0020, 16'h0000, 3, 0);
        chk("read8_value", {16'd0, rdata}, 32'h00A5);
        idle_gap();

        // Illegal requests and a NOP, back-to-back.
        do_req(2'd1, 2'd3, 16'h0100, 16'h0000, 0, 0);
        do_req(2'd3, 2'd1, 16'h0100, 16'h0000, 0, 0);
        do_req(2'd0, 2'd0, 16'h0200, 16'h5555, 0, 0);
        chk("rdata_kept", {16'd0, rdata}, 32'h00A5);
        idle_gap();

        // Reset during BYTE1 of a size-2 write.
        en = 1'b1; mode = 2'd2; size = 2'd2; addr = 16'h4000; wdata = 16'hCAFE; bus_ready = 1'b1;
        @(negedge clk);
        en = 1'b0;
        chk("rst_b0_addr", {16'd0, bus_addr}, 32'h4000);
        mem[16'h4000] = 8'hFE;
        @(negedge clk);
        chk("rst_b1_addr", {16'd0, bus_addr}, 32'h4001);
        chk("rst_b1_we", {31'd0, bus_we}, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        rst = 1'b0; bus_ready = 1'b0; model_rdata = 16'h0000;
        @(negedge clk);
        chk_all_zero("post_mid_reset");
        do_req(2'd1, 2'd1, 16'h4000, 16'h0000, 0, 0);
        chk("after_abort_read", {16'd0, rdata}, 32'h00FE);

        // Randomized traffic with random wait states and back-to-back issue.
        for (int t = 0; t < 80; t++) begin
            m = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(1, 2)) : 2'($urandom);
            s = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(1, 2)) : 2'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            do_req(m, s, a, 16'($urandom), int'($urandom_range(0, 2)), 1);
            if ($urandom_range(0, 1) == 1) idle_gap();
        end
        idle_gap();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
